adaptor2x2_imem_arbiter: RTL and testbench

// - Shares one single-port 1024x32 instruction memory between two Avalon-MM requesters.

---
 rtl/adaptor2x2_imem_arbiter_pkg.sv | 18 +
 rtl/adaptor2x2_imem_arbiter_if.sv | 61 ++++++
 rtl/adaptor2x2_imem_arbiter_rr_arb2.sv | 51 +++++
 rtl/adaptor2x2_imem_arbiter.sv | 145 ++++++++++++++
 tb/tb_adaptor2x2_imem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/adaptor2x2_imem_arbiter_pkg.sv
// Shared types and defaults for the two-requester instruction-memory arbiter.
package adaptor2x2_imem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Requester indices into the grant/request/pending vectors
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

endpackage

// File: rtl/adaptor2x2_imem_arbiter_if.sv
// Bundle of both Avalon-MM requester ports, the memory port and freeze.
// slave  : the arbiter's view; master : the surrounding system's view.
interface adaptor2x2_imem_arbiter_if
  import adaptor2x2_imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) ();

  logic              freeze;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_lock;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_lock;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  freeze,
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output freeze,
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/adaptor2x2_imem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. ptr_q = index of the requester preferred on a
// tie. force_i overrides the pointer update (used when a lock times out).
module adaptor2x2_rr_arb2
  import adaptor2x2_imem_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       force_i,
  input  logic       force_ptr_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  // Grant: single requester wins outright, a tie goes to the preferred one
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i[REQ0] && req_i[REQ1]) begin
        grant_o[REQ0] = (ptr_q == 1'b0);
        grant_o[REQ1] = (ptr_q == 1'b1);
      end else begin
        grant_o = req_i;
      end
    end
  end

  // Pointer: after any grant prefer the other requester, unless forced
  always_comb begin
    ptr_d = ptr_q;
    if (force_i) begin
      ptr_d = force_ptr_i;
    end else if (grant_o[REQ0]) begin
      ptr_d = 1'b1;
    end else if (grant_o[REQ1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register, requester 0 preferred out of reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adaptor2x2_imem_arbiter.sv
// Shares one single-port 1024x32 memory between two Avalon-MM requesters:
// combinational round-robin grant, per-requester lock with timeout, 1-cycle
// read-latency tracking, and freeze (memory clken) handling.
module adaptor2x2_imem_arbiter
  import adaptor2x2_imem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BE_W         = BE_W_DEF,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  adaptor2x2_imem_arbiter_if.slave   bus
);

  localparam int               CNT_W    = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        req, req_arb, grant;
  logic              grant_en, timeout, force_en, force_ptr;
  logic [ADDR_W-1:0] mux_address;
  logic [BE_W-1:0]   mux_byteenable;
  logic [DATA_W-1:0] mux_writedata;
  logic              mux_write;

  assign req[REQ0] = bus.m0_read | bus.m0_write;
  assign req[REQ1] = bus.m1_read | bus.m1_write;
  assign grant_en  = ~bus.freeze & ~reset;
  // A frozen cycle does not advance the lock counter, so it cannot time out either
  assign timeout   = (state_q != ARB) && !bus.freeze && (cnt_q == CNT_LAST);

  // Hide the non-owner from the arbiter while a lock is held
  always_comb begin
    req_arb = req;
    case (state_q)
      LOCK0:   req_arb[REQ1] = 1'b0;
      LOCK1:   req_arb[REQ0] = 1'b0;
      default: req_arb = req;
    endcase
  end

  adaptor2x2_rr_arb2 u_rr (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req_arb),
    .en_i        (grant_en),
    .force_i     (force_en),
    .force_ptr_i (force_ptr),
    .grant_o     (grant)
  );

  // Lock FSM next state, timeout counter and forced pointer hand-over
  always_comb begin
    state_d   = state_q;
    force_en  = 1'b0;
    force_ptr = 1'b0;
    case (state_q)
      ARB: begin
        if (grant[REQ0] && bus.m0_lock) begin
          state_d = LOCK0;
        end else if (grant[REQ1] && bus.m1_lock) begin
          state_d = LOCK1;
        end
      end
      LOCK0: begin
        if (timeout) begin
          state_d   = ARB;
          force_en  = 1'b1;
          force_ptr = 1'b1;
        end else if (!bus.m0_lock) begin
          state_d = ARB;
        end
      end
      LOCK1: begin
        if (timeout) begin
          state_d   = ARB;
          force_en  = 1'b1;
          force_ptr = 1'b0;
        end else if (!bus.m1_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if ((state_q == ARB) || (state_d == ARB)) begin
      cnt_d = '0;
    end else if (!bus.freeze) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // Read+write together is a write: no read data comes back
    pend_d[REQ0] = grant[REQ0] & bus.m0_read & ~bus.m0_write;
    pend_d[REQ1] = grant[REQ1] & bus.m1_read & ~bus.m1_write;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      cnt_q   <= '0;
      pend_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Memory-side mux from the granted requester
  always_comb begin
    mux_address    = bus.m0_address;
    mux_byteenable = bus.m0_byteenable;
    mux_writedata  = bus.m0_writedata;
    mux_write      = grant[REQ0] & bus.m0_write;
    if (grant[REQ1]) begin
      mux_address    = bus.m1_address;
      mux_byteenable = bus.m1_byteenable;
      mux_writedata  = bus.m1_writedata;
      mux_write      = bus.m1_write;
    end
  end

  assign bus.mem_address    = mux_address;
  assign bus.mem_byteenable = mux_byteenable;
  assign bus.mem_writedata  = mux_writedata;
  assign bus.mem_write      = mux_write;
  assign bus.mem_chipselect = |grant;
  assign bus.mem_clken      = ~bus.freeze;

  assign bus.m0_waitrequest   = req[REQ0] & ~grant[REQ0];
  assign bus.m1_waitrequest   = req[REQ1] & ~grant[REQ1];
  // The memory q holds while clken is low, so pending data survives a freeze
  assign bus.m0_readdatavalid = pend_q[REQ0] & ~reset;
  assign bus.m1_readdatavalid = pend_q[REQ1] & ~reset;
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;

endmodule

// File: tb/tb_adaptor2x2_imem_arbiter.sv
// Directed bench for adaptor2x2_imem_arbiter with a scoreboard of per-cycle
// expectations and a behavioural single-port memory (registered address).
module tb_adaptor2x2_imem_arbiter;

  logic clk;
  logic reset;

  adaptor2x2_imem_arbiter_if bus ();

  adaptor2x2_imem_arbiter #(.LOCK_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: address and writes captured on clken & chipselect, q unregistered
  logic [31:0] mem [0:1023];
  logic [9:0]  mem_addr_q = 10'd0;

  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_byteenable[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
        end
      end
      mem_addr_q <= bus.mem_address;
    end
  end

  assign bus.mem_readdata = mem[mem_addr_q];

  // Scoreboard
  typedef struct {
    string       name;
    logic [5:0]  flags;   // wr0 wr1 dv0 dv1 cs clken
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        e;
  logic [5:0]  act;
  logic [31:0] rd;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.m0_waitrequest, bus.m1_waitrequest, bus.m0_readdatavalid,
             bus.m1_readdatavalid, bus.mem_chipselect, bus.mem_clken};
      n_cmp++;
      if (act !== e.flags) begin
        n_fail++;
        $display("FAIL %s: wr0/wr1/dv0/dv1/cs/clken got %b want %b", e.name, act, e.flags);
      end
      if (e.flags[3] || e.flags[2]) begin
        rd = e.flags[3] ? bus.m0_readdata : bus.m1_readdata;
        n_cmp++;
        if (rd !== e.data) begin
          n_fail++;
          $display("FAIL %s_data: readdata got %h want %h", e.name, rd, e.data);
        end
      end
    end
  end

  task automatic step(input string nm, input logic wr0, input logic wr1, input logic dv0,
                      input logic dv1, input logic cs, input logic [31:0] data);
    exp_t x;
    x.name  = nm;
    x.flags = {wr0, wr1, dv0, dv1, cs, ~bus.freeze};
    x.data  = data;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic rq0(input logic r, input logic w, input logic [9:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic lk);
    bus.m0_read = r; bus.m0_write = w; bus.m0_address = a;
    bus.m0_writedata = wd; bus.m0_byteenable = be; bus.m0_lock = lk;
  endtask

  task automatic rq1(input logic r, input logic w, input logic [9:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic lk);
    bus.m1_read = r; bus.m1_write = w; bus.m1_address = a;
    bus.m1_writedata = wd; bus.m1_byteenable = be; bus.m1_lock = lk;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[10'h005] = 32'hDEAD_BEEF;
    mem[10'h3FF] = 32'hAAAA_AAAA;

    reset = 1'b1;
    bus.freeze = 1'b0;
    rq0(0, 0, 0, 0, 0, 0);
    rq1(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset: requests are held off, nothing valid
    step("rst_idle", 0, 0, 0, 0, 0, 0);
    rq0(1, 0, 10'h005, 0, 0, 0);
    rq1(0, 1, 10'h100, 32'h1111_1111, 4'hF, 0);
    step("rst_req", 1, 1, 0, 0, 0, 0);

    // Single m0 read
    reset = 1'b0;
    rq1(0, 0, 0, 0, 0, 0);
    step("m0_rd", 0, 0, 0, 0, 1, 0);
    rq0(0, 0, 0, 0, 0, 0);
    step("m0_rdv", 0, 0, 1, 0, 0, 32'hDEAD_BEEF);

    // Alternating grants 0,1,0,1 with continuous reads
    rq1(1, 0, 10'h010, 0, 0, 0);
    step("m1_rd", 0, 0, 0, 0, 1, 0);
    rq0(1, 0, 10'h001, 0, 0, 0);
    rq1(1, 0, 10'h002, 0, 0, 0);
    step("alt0", 0, 1, 0, 1, 1, 32'hA000_0010);
    rq0(1, 0, 10'h003, 0, 0, 0);
    step("alt1", 1, 0, 1, 0, 1, 32'hA000_0001);
    rq1(1, 0, 10'h004, 0, 0, 0);
    step("alt2", 0, 1, 0, 1, 1, 32'hA000_0002);
    rq0(0, 0, 0, 0, 0, 0);
    step("alt3", 0, 0, 1, 0, 1, 32'hA000_0003);
    rq1(0, 0, 0, 0, 0, 0);
    step("alt4", 0, 0, 0, 1, 0, 32'hA000_0004);

    // Partial byteenable write, then read back
    rq1(0, 1, 10'h3FF, 32'h1234_5678, 4'h3, 0);
    step("wr_be", 0, 0, 0, 0, 1, 0);
    rq1(1, 0, 10'h3FF, 0, 0, 0);
    step("rd_be", 0, 0, 0, 0, 1, 0);
    rq1(0, 0, 0, 0, 0, 0);
    step("rd_be_dv", 0, 0, 0, 1, 0, 32'hAAAA_5678);

    // Read+write together acts as a write; read right after sees new data
    rq0(1, 1, 10'h020, 32'hCAFE_F00D, 4'hF, 0);
    step("rw_both", 0, 0, 0, 0, 1, 0);
    rq0(1, 0, 10'h020, 0, 0, 0);
    step("raw_rd", 0, 0, 0, 0, 1, 0);
    rq0(0, 0, 0, 0, 0, 0);
    step("raw_dv", 0, 0, 1, 0, 0, 32'hCAFE_F00D);

    // m1 lock held with continuous reads; timeout after 8 cycles
    rq1(1, 0, 10'h030, 0, 0, 1);
    step("lk_grant", 0, 0, 0, 0, 1, 0);
    rq0(1, 0, 10'h040, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("lk_block", 1, 0, 0, 1, 1, 32'hA000_0030);
    step("lk_timeout", 0, 1, 0, 1, 1, 32'hA000_0030);
    rq0(0, 0, 0, 0, 0, 0);
    step("lk_relock", 0, 0, 1, 0, 1, 32'hA000_0040);
    rq1(0, 0, 0, 0, 0, 0);
    step("lk_drop", 0, 0, 0, 1, 0, 32'hA000_0030);
    rq0(1, 0, 10'h041, 0, 0, 0);
    step("lk_free", 0, 0, 0, 0, 1, 0);
    rq0(0, 0, 0, 0, 0, 0);
    step("lk_free_dv", 0, 0, 1, 0, 0, 32'hA000_0041);

    // Freeze for 3 cycles right after a read grant
    rq0(1, 0, 10'h050, 0, 0, 0);
    step("fz_grant", 0, 0, 0, 0, 1, 0);
    bus.freeze = 1'b1;
    rq0(1, 0, 10'h051, 0, 0, 0);
    rq1(1, 0, 10'h052, 0, 0, 0);
    step("fz_0", 1, 1, 1, 0, 0, 32'hA000_0050);
    step("fz_1", 1, 1, 0, 0, 0, 0);
    step("fz_2", 1, 1, 0, 0, 0, 0);
    bus.freeze = 1'b0;
    step("fz_end", 1, 0, 0, 0, 1, 0);
    rq1(0, 0, 0, 0, 0, 0);
    step("fz_m0", 0, 0, 0, 1, 1, 32'hA000_0052);
    rq0(0, 0, 0, 0, 0, 0);
    step("fz_dv", 0, 0, 1, 0, 0, 32'hA000_0051);

    // Reset the cycle after an m1 read grant
    rq1(1, 0, 10'h060, 0, 0, 0);
    step("rr_grant", 0, 0, 0, 0, 1, 0);
    rq1(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("rr_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    rq0(1, 0, 10'h061, 0, 0, 0);
    rq1(1, 0, 10'h062, 0, 0, 0);
    step("rr_ptr", 0, 1, 0, 0, 1, 0);
    rq0(0, 0, 0, 0, 0, 0);
    step("rr_m1", 0, 0, 1, 0, 1, 32'hA000_0061);
    rq1(0, 0, 0, 0, 0, 0);
    step("rr_dv", 0, 0, 0, 1, 0, 32'hA000_0062);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
